// File: rtl/mux_rr_nway_pkg.sv
// Shared constants for the N-way registered mux.
//   MUX_DEF_WIDTH / MUX_DEF_NUM_IN : default channel width and count
//   MUX_MODE_FIXED / MUX_MODE_RR   : encodings of the mode input
package mux_rr_nway_pkg;
  localparam int   MUX_DEF_WIDTH  = 32;
  localparam int   MUX_DEF_NUM_IN = 4;
  localparam logic MUX_MODE_FIXED = 1'b0;
  localparam logic MUX_MODE_RR    = 1'b1;
endpackage

// File: rtl/mux_rr_nway_rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_req     : per-channel request
//   i_ptr     : index of the last winner; search starts at i_ptr+1 and wraps
//   o_gnt     : one-hot grant (all zero when nothing requests)
//   o_gnt_idx : index of the granted channel (0 when nothing requests)
module rr_arbiter #(
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] i_req,
  input  logic [SEL_W-1:0]  i_ptr,
  output logic [NUM_IN-1:0] o_gnt,
  output logic [SEL_W-1:0]  o_gnt_idx
);
  int   w_pos;
  logic w_found;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_pos     = 0;
    // Walk NUM_IN positions after ptr; the last step lands on ptr itself,
    // so the previous winner only wins again when nobody else requests.
    for (int k = 1; k <= NUM_IN; k++) begin
      w_pos = (int'(i_ptr) + k) % NUM_IN;
      if (!w_found && i_req[w_pos]) begin
        w_found      = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_gnt_idx    = SEL_W'(w_pos);
      end
    end
  end
endmodule

// File: rtl/mux_rr_nway.sv
// N-input registered mux with valid/ready handshake. Picks a channel by
// explicit select (fixed mode) or round-robin, and holds the winner in a
// single output register.
//   clk, rst_n            : clock, async active-low reset
//   mode                  : MUX_MODE_FIXED / MUX_MODE_RR
//   sel                   : channel used in fixed mode (out of range = none)
//   in_data/in_valid      : channel i at in_data[i*WIDTH +: WIDTH]
//   in_ready              : one-hot or zero, combinational
//   out_data/out_valid/out_sel : output register, out_sel is source index
//   out_ready             : consumer accepts the held word
module mux_rr_nway
  import mux_rr_nway_pkg::*;
#(
  parameter  int WIDTH  = MUX_DEF_WIDTH,
  parameter  int NUM_IN = MUX_DEF_NUM_IN,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_sel
);
  logic [WIDTH-1:0]  r_data;
  logic              r_valid;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  r_ptr;

  logic              w_can_load;
  logic              w_sel_ok;
  logic              w_xfer;
  logic [NUM_IN-1:0] w_arb_gnt;
  logic [SEL_W-1:0]  w_arb_idx;
  logic [NUM_IN-1:0] w_cand;
  logic [SEL_W-1:0]  w_cand_idx;
  logic [NUM_IN-1:0] w_ready;
  logic [WIDTH-1:0]  w_win_data;

  assign w_can_load = ~r_valid | out_ready;
  // Only matters when NUM_IN is not a power of two.
  assign w_sel_ok   = ({1'b0, sel} < (SEL_W+1)'(NUM_IN));

  rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .i_req     (in_valid),
    .i_ptr     (r_ptr),
    .o_gnt     (w_arb_gnt),
    .o_gnt_idx (w_arb_idx)
  );

  // Fixed mode offers ready to sel even if it is not valid; RR mode only
  // has a candidate when some channel is valid.
  always_comb begin
    w_cand     = '0;
    w_cand_idx = '0;
    if (mode == MUX_MODE_RR) begin
      w_cand     = w_arb_gnt;
      w_cand_idx = w_arb_idx;
    end else if (w_sel_ok) begin
      w_cand_idx = sel;
      for (int i = 0; i < NUM_IN; i++) w_cand[i] = (sel == SEL_W'(i));
    end
  end

  assign w_ready    = (rst_n && w_can_load) ? w_cand : '0;
  assign w_xfer     = |(in_valid & w_ready);
  assign w_win_data = in_data[int'(w_cand_idx)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= SEL_W'(NUM_IN-1);
    end else begin
      if (w_xfer) begin
        r_valid <= 1'b1;
        r_data  <= w_win_data;
        r_sel   <= w_cand_idx;
        if (mode == MUX_MODE_RR) r_ptr <= w_cand_idx;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_ready;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_sel   = r_sel;
endmodule

// File: tb/tb_mux_rr_nway.sv
module tb_mux_rr_nway;
  import mux_rr_nway_pkg::*;
  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           mode;
  logic [1:0]     sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid, out_ready;
  logic [1:0]     out_sel;

  // NUM_IN=5 variant for out-of-range select
  logic           mode5 = MUX_MODE_FIXED;
  logic [2:0]     sel5;
  logic [5*W-1:0] in_data5;
  logic [4:0]     in_valid5, in_ready5;
  logic [W-1:0]   out_data5;
  logic           out_valid5;
  logic           out_ready5 = 1'b1;
  logic [2:0]     out_sel5;

  mux_rr_nway #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel)
  );

  mux_rr_nway #(.WIDTH(W), .NUM_IN(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5),
    .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready5),
    .out_sel(out_sel5)
  );

  int checks = 0;
  int failures = 0;

  typedef struct { logic [W-1:0] data; logic [1:0] sel; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic m; logic [1:0] s; logic [3:0] v; logic ordy; logic [3:0] rdy; int ov;
  } vec_t;
  vec_t tbl[11];

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endfunction

  // Words are compared against the scoreboard when they leave the register.
  exp_t e_mon;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL consume_unexpected: got sel %0d data %0h, want none", out_sel, out_data);
      end else begin
        e_mon = sb.pop_front();
        chk("consume_data", out_data, e_mon.data);
        chk("consume_sel", W'(out_sel), W'(e_mon.sel));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle, check in_ready (and out_valid unless ov<0), queue any transfer.
  task automatic step(input logic m, input logic [1:0] s, input logic [3:0] v,
                      input logic ordy, input logic [3:0] rdy, input int ov,
                      input string nm);
    exp_t e;
    mode = m; sel = s; in_valid = v; out_ready = ordy;
    #1;
    chk({nm, "_rdy"}, W'(in_ready), W'(rdy));
    if (ov >= 0) chk({nm, "_ov"}, W'(out_valid), W'(ov));
    for (int i = 0; i < N; i++) begin
      if (rdy[i] && v[i]) begin
        e.data = in_data[i*W +: W];
        e.sel  = 2'(i);
        sb.push_back(e);
      end
    end
    tick();
  endtask

  localparam logic F = MUX_MODE_FIXED;
  localparam logic R = MUX_MODE_RR;

  initial begin
    mode = F; sel = 0; in_valid = 0; out_ready = 0;
    in_data = {32'h3333_3333, 32'hAAAA_AAAA, 32'h1111_1111, 32'h5555_5555};
    sel5 = 0; in_valid5 = 0;
    in_data5 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0};

    //            m  s  v        ordy rdy      ov
    tbl[0]  = '{F, 2, 4'b0101, 1, 4'b0100, 0};
    tbl[1]  = '{F, 2, 4'b0000, 1, 4'b0100, 1};
    tbl[2]  = '{F, 1, 4'b0000, 0, 4'b0010, 0};
    tbl[3]  = '{F, 1, 4'b0010, 0, 4'b0010, 0};
    tbl[4]  = '{F, 0, 4'b1111, 0, 4'b0000, 1};
    tbl[5]  = '{R, 0, 4'b1111, 0, 4'b0000, 1};
    tbl[6]  = '{R, 0, 4'b1111, 1, 4'b0001, 1};
    tbl[7]  = '{R, 0, 4'b1100, 1, 4'b0100, 1};
    tbl[8]  = '{R, 0, 4'b0000, 1, 4'b0000, 1};
    tbl[9]  = '{R, 0, 4'b0011, 0, 4'b0001, 0};
    tbl[10] = '{F, 3, 4'b0000, 1, 4'b1000, 1};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    mode = R; in_valid = 4'hF; #1;
    chk("rst_ov", W'(out_valid), 0);
    chk("rst_data", out_data, 0);
    chk("rst_sel", W'(out_sel), 0);
    chk("rst_rdy", W'(in_ready), 0);
    in_valid = 0;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      step(tbl[i].m, tbl[i].s, tbl[i].v, tbl[i].ordy, tbl[i].rdy, tbl[i].ov,
           $sformatf("tbl%0d", i));

    // reset mid-stream with a held word
    step(R, 0, 4'hF, 0, 4'b0010, 0, "prerst");
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ov", W'(out_valid), 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_sel", W'(out_sel), 0);
    chk("midrst_rdy", W'(in_ready), 0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // RR fairness: 0,1,2,3,0,1,2,3 with no bubbles
    in_data = {32'h3, 32'h2, 32'h1, 32'h0};
    for (int c = 0; c < 8; c++)
      step(R, 0, 4'hF, 1, 4'(1 << (c % 4)), (c == 0) ? 0 : 1, $sformatf("fair%0d", c));

    // backpressure: word from ch3 held stable
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp%0d_data", c), out_data, 32'h3);
      chk($sformatf("bp%0d_sel", c), W'(out_sel), 3);
      step(R, 0, 4'hF, 0, 4'b0000, 1, $sformatf("bp%0d", c));
    end
    step(R, 0, 4'hF, 1, 4'b0001, 1, "bp_release");

    // skip and wrap: ptr 0 -> 2, then ch3, then wrap to ch1
    step(R, 0, 4'b0100, 1, 4'b0100, 1, "skip_p2");
    step(R, 0, 4'b1010, 1, 4'b1000, 1, "skip_ch3");
    step(R, 0, 4'b1010, 1, 4'b0010, 1, "wrap_ch1");

    // mode switch: fixed ch0 leaves ptr at 1, so RR resumes at ch2
    step(F, 0, 4'hF, 1, 4'b0001, 1, "msw_fixed");
    step(R, 0, 4'hF, 1, 4'b0100, 1, "msw_rr");
    step(R, 0, 4'h0, 1, 4'b0000, 1, "drain");
    step(R, 0, 4'h0, 1, 4'b0000, 0, "idle");
    chk("sb_empty", W'(sb.size()), 0);

    // out-of-range select on a 5-input instance
    sel5 = 3'd4; in_valid5 = 5'h10; #1;
    chk("n5_sel4_rdy", W'(in_ready5), W'(5'h10));
    tick();
    chk("n5_data", out_data5, 32'h4444_4444);
    chk("n5_sel", W'(out_sel5), 4);
    chk("n5_ov", W'(out_valid5), 1);
    in_valid5 = 5'h1F;
    for (int s = 5; s < 8; s++) begin
      sel5 = 3'(s); #1;
      chk($sformatf("n5_sel%0d_rdy", s), W'(in_ready5), 0);
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
